// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory port arbiter.
// Holds the return-owner encoding, default bus widths and the alignment check.
package arm_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_I    = 2'd1,
        RET_D    = 2'd2
    } ret_owner_t;

    function automatic logic isAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, memory-stage data port and single-port RAM signals.
// slave is the arbiter's view; master is the core-plus-RAM view.
interface mem_port_arbiter_if
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles a pending fetch lost to a data access.
// at_max flags the point where the fetch must be force-granted.
module mem_starve_ctr
    import arm_mem_pkg::*;
#(
    parameter int MAX_COUNT = 3
) (
    input  logic CLK,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_W-1:0] MAX_VAL = STARVE_W'(MAX_COUNT);

    logic [STARVE_W-1:0] countReg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            countReg <= '0;
        end else if (clr) begin
            countReg <= '0;
        end else if (inc && (countReg != MAX_VAL)) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign at_max = (countReg == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the memory stage.
// Data wins by default; a starved fetch is force-granted, and read data is steered back to its owner.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic                 CLK,
    input  logic                 Reset,
    mem_port_arbiter_if.slave    bus,
    output logic [31:0]          stall_cnt
);

    logic       starveAtMax;
    logic       iWins;
    logic       iGnt;
    logic       dGnt;
    logic       dAligned;
    logic       unusedFetchLowBits;

    ret_owner_t  retStateReg;
    logic        dErrReg;
    logic [31:0] stallCntReg;

    logic [1:0]        laneValid;
    logic [DATA_W-1:0] laneData [2];

    assign dAligned           = isAligned(bus.d_addr[1:0]);
    assign unusedFetchLowBits = ^bus.i_addr[1:0];

    // Fetch only beats a simultaneous data request once it has waited STARVE_MAX cycles.
    assign iWins = bus.i_req & (~bus.d_req | starveAtMax);
    assign iGnt  = ~Reset & iWins;
    assign dGnt  = ~Reset & bus.d_req & ~iWins;

    mem_starve_ctr #(
        .MAX_COUNT (STARVE_MAX)
    ) u_starve_ctr (
        .CLK    (CLK),
        .Reset  (Reset),
        .inc    (bus.i_req & bus.d_req & ~iGnt),
        .clr    (iGnt | ~bus.i_req),
        .at_max (starveAtMax)
    );

    assign bus.i_gnt     = iGnt;
    assign bus.d_gnt     = dGnt;
    assign bus.mem_en    = iGnt | dGnt;
    assign bus.mem_we    = dGnt & bus.d_we & dAligned;
    assign bus.mem_addr  = dGnt ? bus.d_addr[ADDR_W-1:2] : bus.i_addr[ADDR_W-1:2];
    assign bus.mem_wdata = bus.d_wdata;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            retStateReg <= RET_NONE;
            dErrReg     <= 1'b0;
            stallCntReg <= '0;
        end else begin
            if (iGnt) begin
                retStateReg <= RET_I;
            end else if (dGnt && !bus.d_we) begin
                retStateReg <= RET_D;
            end else begin
                retStateReg <= RET_NONE;
            end
            dErrReg <= dGnt & ~dAligned;
            if (bus.i_req && !iGnt && (stallCntReg != 32'hFFFF_FFFF)) begin
                stallCntReg <= stallCntReg + 32'd1;
            end
        end
    end

    // Lane 0 returns to fetch, lane 1 to the data port; a return in flight at reset is dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : genRetLane
            assign laneValid[gi] = ~Reset && (retStateReg == ((gi == 0) ? RET_I : RET_D));
            assign laneData[gi]  = laneValid[gi] ? bus.mem_rdata : '0;
        end
    endgenerate

    assign bus.i_rvalid = laneValid[0];
    assign bus.i_rdata  = laneData[0];
    assign bus.d_rvalid = laneValid[1];
    assign bus.d_rdata  = laneData[1];
    assign bus.d_err    = dErrReg;
    assign stall_cnt    = stallCntReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for steady traffic plus
// hand-written reset sequences, against a small synchronous RAM model.
module tb_mem_port_arbiter;
    import arm_mem_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;
    localparam int NVEC       = 19;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] stall_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    logic [31:0] ram [256];

    always @(posedge CLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    typedef struct {
        string       tag;
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        eIGnt;
        logic        eDGnt;
        logic        eEn;
        logic        eWe;
        logic [29:0] eAddr;
        logic        eIRv;
        logic [31:0] eIRdata;
        logic        eDRv;
        logic [31:0] eDRdata;
        logic        eErr;
        logic [31:0] eStall;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input string tag,
                                input logic iReq, input logic [31:0] iAddr,
                                input logic dReq, input logic dWe,
                                input logic [31:0] dAddr, input logic [31:0] dWdata,
                                input logic eIGnt, input logic eDGnt, input logic eEn,
                                input logic eWe, input logic [29:0] eAddr,
                                input logic eIRv, input logic [31:0] eIRdata,
                                input logic eDRv, input logic [31:0] eDRdata,
                                input logic eErr, input logic [31:0] eStall);
        vec_t v;
        v.tag = tag;   v.iReq = iReq;   v.iAddr = iAddr;
        v.dReq = dReq; v.dWe = dWe;     v.dAddr = dAddr;  v.dWdata = dWdata;
        v.eIGnt = eIGnt; v.eDGnt = eDGnt; v.eEn = eEn; v.eWe = eWe; v.eAddr = eAddr;
        v.eIRv = eIRv; v.eIRdata = eIRdata; v.eDRv = eDRv; v.eDRdata = eDRdata;
        v.eErr = eErr; v.eStall = eStall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                         input logic dWe, input logic [31:0] dAddr, input logic [31:0] dWdata);
        bus.i_req   = iReq;
        bus.i_addr  = iAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic eI, input logic eD);
        chk({tag, ".i_gnt"}, 32'(bus.i_gnt), 32'(eI));
        chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 32'(eD));
        $display("[TB] %s: i_gnt=%0b d_gnt=%0b stall_cnt=%0d", tag, bus.i_gnt, bus.d_gnt, stall_cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'(i);

        //              tag      iReq iAddr   dReq dWe dAddr   dWdata         iG dG en we addr   iRv iRd           dRv dRd           err stall
        vecs[0]  = mk("fetch0",  1, 32'h10, 0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 30'h4,  0, 32'h0,         0, 32'h0,         0, 0);
        vecs[1]  = mk("fetch1",  1, 32'h14, 0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 30'h5,  1, 32'h4,         0, 32'h0,         0, 0);
        vecs[2]  = mk("fetch2",  1, 32'h18, 0, 0, 32'h0,  32'h0,         1, 0, 1, 0, 30'h6,  1, 32'h5,         0, 32'h0,         0, 0);
        vecs[3]  = mk("idle3",   0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 30'h0,  1, 32'h6,         0, 32'h0,         0, 0);
        vecs[4]  = mk("dwrite",  0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF,  0, 1, 1, 1, 30'h10, 0, 32'h0,         0, 32'h0,         0, 0);
        vecs[5]  = mk("dread",   0, 32'h0,  1, 0, 32'h40, 32'h0,         0, 1, 1, 0, 30'h10, 0, 32'h0,         0, 32'h0,         0, 0);
        vecs[6]  = mk("idle6",   0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 30'h0,  0, 32'h0,         1, 32'hDEADBEEF,  0, 0);
        vecs[7]  = mk("miswr",   0, 32'h0,  1, 1, 32'h42, 32'h12345678,  0, 1, 1, 0, 30'h10, 0, 32'h0,         0, 32'h0,         0, 0);
        vecs[8]  = mk("reread",  0, 32'h0,  1, 0, 32'h40, 32'h0,         0, 1, 1, 0, 30'h10, 0, 32'h0,         0, 32'h0,         1, 0);
        vecs[9]  = mk("idle9",   0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 30'h0,  0, 32'h0,         1, 32'hDEADBEEF,  0, 0);
        vecs[10] = mk("misrd",   0, 32'h0,  1, 0, 32'h13, 32'h0,         0, 1, 1, 0, 30'h4,  0, 32'h0,         0, 32'h0,         0, 0);
        vecs[11] = mk("idle11",  0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 30'h0,  0, 32'h0,         1, 32'h4,         1, 0);
        vecs[12] = mk("cont0",   1, 32'h20, 1, 0, 32'h24, 32'h0,         0, 1, 1, 0, 30'h9,  0, 32'h0,         0, 32'h0,         0, 0);
        vecs[13] = mk("cont1",   1, 32'h20, 1, 0, 32'h24, 32'h0,         0, 1, 1, 0, 30'h9,  0, 32'h0,         1, 32'h9,         0, 1);
        vecs[14] = mk("cont2",   1, 32'h20, 1, 0, 32'h24, 32'h0,         0, 1, 1, 0, 30'h9,  0, 32'h0,         1, 32'h9,         0, 2);
        vecs[15] = mk("cont3",   1, 32'h20, 1, 0, 32'h24, 32'h0,         1, 0, 1, 0, 30'h8,  0, 32'h0,         1, 32'h9,         0, 3);
        vecs[16] = mk("cont4",   1, 32'h20, 1, 0, 32'h24, 32'h0,         0, 1, 1, 0, 30'h9,  1, 32'h8,         0, 32'h0,         0, 3);
        vecs[17] = mk("cont5",   1, 32'h20, 1, 0, 32'h24, 32'h0,         0, 1, 1, 0, 30'h9,  0, 32'h0,         1, 32'h9,         0, 4);
        vecs[18] = mk("idle18",  0, 32'h0,  0, 0, 32'h0,  32'h0,         0, 0, 0, 0, 30'h0,  0, 32'h0,         1, 32'h9,         0, 5);

        // Reset held with both ports requesting: nothing may reach the RAM.
        Reset = 1'b1;
        setIn(1, 32'h10, 1, 1, 32'h40, 32'hFFFF_FFFF);
        @(negedge CLK);
        chk("rst.i_gnt",  32'(bus.i_gnt),  0);
        chk("rst.d_gnt",  32'(bus.d_gnt),  0);
        chk("rst.mem_en", 32'(bus.mem_en), 0);
        chk("rst.mem_we", 32'(bus.mem_we), 0);
        $display("[TB] reset held: i_gnt=%0b d_gnt=%0b mem_en=%0b", bus.i_gnt, bus.d_gnt, bus.mem_en);
        nextCycle();

        Reset = 1'b0;
        setIn(0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("post_rst.i_rvalid",  32'(bus.i_rvalid), 0);
        chk("post_rst.d_rvalid",  32'(bus.d_rvalid), 0);
        chk("post_rst.i_rdata",   bus.i_rdata,       0);
        chk("post_rst.d_rdata",   bus.d_rdata,       0);
        chk("post_rst.d_err",     32'(bus.d_err),    0);
        chk("post_rst.stall_cnt", stall_cnt,         0);
        $display("[TB] after reset: rvalid i/d=%0b/%0b stall_cnt=%0d", bus.i_rvalid, bus.d_rvalid, stall_cnt);
        nextCycle();

        for (int v = 0; v < NVEC; v++) begin
            setIn(vecs[v].iReq, vecs[v].iAddr, vecs[v].dReq, vecs[v].dWe, vecs[v].dAddr, vecs[v].dWdata);
            @(negedge CLK);
            chk({vecs[v].tag, ".i_gnt"},     32'(bus.i_gnt),    32'(vecs[v].eIGnt));
            chk({vecs[v].tag, ".d_gnt"},     32'(bus.d_gnt),    32'(vecs[v].eDGnt));
            chk({vecs[v].tag, ".mem_en"},    32'(bus.mem_en),   32'(vecs[v].eEn));
            chk({vecs[v].tag, ".mem_we"},    32'(bus.mem_we),   32'(vecs[v].eWe));
            if (vecs[v].eEn) chk({vecs[v].tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(vecs[v].eAddr));
            chk({vecs[v].tag, ".i_rvalid"},  32'(bus.i_rvalid), 32'(vecs[v].eIRv));
            chk({vecs[v].tag, ".i_rdata"},   bus.i_rdata,       vecs[v].eIRdata);
            chk({vecs[v].tag, ".d_rvalid"},  32'(bus.d_rvalid), 32'(vecs[v].eDRv));
            chk({vecs[v].tag, ".d_rdata"},   bus.d_rdata,       vecs[v].eDRdata);
            chk({vecs[v].tag, ".d_err"},     32'(bus.d_err),    32'(vecs[v].eErr));
            chk({vecs[v].tag, ".stall_cnt"}, stall_cnt,         vecs[v].eStall);
            $display("[TB] %s: gnt i/d=%0b/%0b mem_en=%0b mem_we=%0b addr=0x%0h rv i/d=%0b/%0b rdata i/d=0x%08h/0x%08h err=%0b stall=%0d",
                     vecs[v].tag, bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr,
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, bus.d_err, stall_cnt);
            nextCycle();
        end

        // Reset arrives the cycle after a fetch grant; the return must be dropped.
        setIn(1, 32'h30, 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        checkGrant("midrd.fetch", 1, 0);
        nextCycle();

        Reset = 1'b1;
        setIn(1, 32'h30, 1, 1, 32'h44, 32'hFFFF_FFFF);
        @(negedge CLK);
        chk("midrd.rst.mem_en", 32'(bus.mem_en), 0);
        chk("midrd.rst.mem_we", 32'(bus.mem_we), 0);
        checkGrant("midrd.rst", 0, 0);
        nextCycle();

        Reset = 1'b0;
        setIn(1, 32'h34, 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("midrd.after.i_rvalid",  32'(bus.i_rvalid), 0);
        chk("midrd.after.i_rdata",   bus.i_rdata,       0);
        chk("midrd.after.stall_cnt", stall_cnt,         0);
        chk("midrd.after.mem_addr",  32'(bus.mem_addr), 32'd13);
        checkGrant("midrd.after", 1, 0);
        nextCycle();

        setIn(0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("midrd.ret.i_rvalid", 32'(bus.i_rvalid), 1);
        chk("midrd.ret.i_rdata",  bus.i_rdata,       32'd13);
        $display("[TB] midrd.ret: i_rvalid=%0b i_rdata=0x%08h", bus.i_rvalid, bus.i_rdata);
        nextCycle();

        // Build up starvation, reset, then confirm the full wait is needed again.
        for (int k = 0; k < 2; k++) begin
            setIn(1, 32'h20, 1, 0, 32'h24, 32'h0);
            @(negedge CLK);
            checkGrant($sformatf("starve.pre%0d", k), 0, 1);
            nextCycle();
        end
        Reset = 1'b1;
        setIn(0, 32'h0, 0, 0, 32'h0, 32'h0);
        nextCycle();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            setIn(1, 32'h20, 1, 0, 32'h24, 32'h0);
            @(negedge CLK);
            checkGrant($sformatf("starve.post%0d", k), (k == 3), (k != 3));
            nextCycle();
        end
        setIn(0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("starve.stall_cnt", stall_cnt, 32'd3);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous data/instruction RAM between the pipeline's instruction-fetch port and its memory-stage data port, so the core can run from one unified memory. Data accesses from the memory stage take priority, and a starvation counter forces a fetch grant after a bounded wait. Read data returns one cycle after the grant and is steered back to the requester that issued it. The block sits between the core's fetch/memory-stage ports and the RAM; ungranted requests drive the core's stall inputs.

## Interface
- ADDR_W, 32: byte-address width of both requesters.
- DATA_W, 32: data word width.
- STARVE_MAX, 3: number of consecutive cycles a pending fetch may lose before it is force-granted (1..15).

- CLK  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch granted this cycle; core stalls Fetch while i_req & ~i_gnt.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data access granted this cycle.
- d_rvalid  out  1  d_rdata valid (reads only).
- d_rdata  out  DATA_W  read word.
- d_err  out  1  one-cycle pulse: a granted data access was misaligned.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W-2  RAM word address, equal to the granted address[ADDR_W-1:2].
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after an mem_en & ~mem_we access.
- stall_cnt  out  32  saturating count of cycles with i_req & ~i_gnt.

## Operation
- At most one grant per cycle. Grants are combinational from the requests and registered state.
- Priority: d_req wins by default. i_req wins when starve_ctr == STARVE_MAX.
- starve_ctr: increments (saturating at STARVE_MAX) on i_req & d_req & ~i_gnt. Clears on i_gnt or ~i_req.
- Grant drives mem_en=1, mem_addr and mem_wdata from the winner. mem_we = d_gnt & d_we & aligned.
- Misaligned data access (d_addr[1:0] != 0) is still granted. The write is suppressed, and d_err is registered high for the following cycle. A misaligned read returns the word at d_addr[ADDR_W-1:2] with d_err=1.
- Fetch addresses are assumed aligned. Low bits are ignored.
- Return-owner FSM (registered), with three states:
  - RET_NONE: no read was granted last cycle.
  - RET_I: a fetch was granted last cycle.
  - RET_D: a data read was granted last cycle.
- Next state each cycle: RET_I on i_gnt; RET_D on d_gnt & ~d_we; otherwise RET_NONE.
- i_rvalid = (state == RET_I); d_rvalid = (state == RET_D).
- Each rdata output is mem_rdata while its rvalid is 1, and 0 otherwise.
- stall_cnt increments on i_req & ~i_gnt and saturates at 0xFFFFFFFF.

## Timing
- Grant latency is 0 cycles: a request is granted in the same cycle it is presented.
- Read data latency is 1 cycle after the grant. Throughput is one access per cycle, back-to-back.
- A write completes at the clock edge of its grant. No rvalid is produced for writes.
- A requester holds req/addr/we/wdata stable until its gnt. Dropping req before gnt is legal and counts as no request.
- Simultaneous requests with starve_ctr < STARVE_MAX: d_gnt=1, i_gnt=0, counter increments.
- Simultaneous requests with starve_ctr == STARVE_MAX: i_gnt=1, d_gnt=0, counter clears.
- Worst-case fetch wait is STARVE_MAX cycles.
- No requests: mem_en=0, and the FSM goes to RET_NONE next cycle.
- Reset values (all registered state): starve_ctr=0, FSM=RET_NONE, d_err=0, stall_cnt=0. As a result i_rvalid=d_rvalid=0 and i_rdata=d_rdata=0.
- While Reset is high, i_gnt=d_gnt=mem_en=mem_we=0.
- Reset asserted while a read is outstanding: the return is discarded, and rvalid is 0 in the following cycle.

## Structure
- Shared package arm_mem_pkg holds:
  - the enum ret_owner_t {RET_NONE, RET_I, RET_D};
  - default ADDR_W/DATA_W constants;
  - the alignment-check function.
- One sub-module, mem_starve_ctr: the saturating starvation counter, with inputs inc/clr and output at_max.
- The arbiter, return FSM, error flag and stall counter stay in mem_port_arbiter.

## Test plan
- Fetch only: i_req=1 with i_addr=0x10, then 0x14, then 0x18; RAM preloaded with word n = n. Required: i_gnt=1 every cycle, mem_addr = 4, 5, 6; i_rvalid=1 one cycle later with i_rdata = 4, 5, 6; stall_cnt=0.
- Contention with STARVE_MAX=3: i_req and d_req held high for 6 cycles. Required grant sequence D, D, D, I, D, D; stall_cnt=5 afterwards.
- Data write then read: write 0xDEADBEEF to 0x40, then read 0x40. Required: mem_we=1 only in the write cycle, no d_rvalid for the write, d_rvalid=1 with d_rdata=0xDEADBEEF one cycle after the read grant.
- Misaligned write: d_we=1, d_addr=0x42. Required: d_gnt=1, mem_we=0, d_err=1 for exactly one cycle, RAM word 0x10 unchanged.
- Reset mid-read: grant a fetch, then assert Reset in the next cycle. Required: i_rvalid=0, starve_ctr=0, stall_cnt=0 after reset; normal grants resume in the first cycle after Reset deasserts.
